// File: rtl/automata_decoder.sv
// Observer for the six-state control automaton's C bus: rebuilds the state trajectory,
// flags codes that are illegal for the tracked state and re-synchronises on any listed code.
module automata_decoder #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_valid,
   input  logic [7:0]       c_code,
   output logic [2:0]       state,
   output logic             sync,
   output logic             tr_valid,
   output logic [3:0]       tr_id,
   output logic             err,
   output logic [CNT_W-1:0] step_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [2:0] N0 = 3'd0;
   localparam logic [2:0] N1 = 3'd1;
   localparam logic [2:0] N2 = 3'd2;
   localparam logic [2:0] N3 = 3'd3;
   localparam logic [2:0] N4 = 3'd4;
   localparam logic [2:0] N5 = 3'd5;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             hit;
   logic [3:0]       hit_id;
   logic [2:0]       hit_src;
   logic [2:0]       hit_dst;
   logic             idle_ok;
   logic [CNT_W-1:0] step_inc;
   logic [CNT_W-1:0] err_inc;

   logic [2:0]       state_nx;
   logic             sync_nx;
   logic             tr_valid_nx;
   logic [3:0]       tr_id_nx;
   logic             err_nx;
   logic [CNT_W-1:0] step_cnt_nx;
   logic [CNT_W-1:0] err_cnt_nx;

   // Code lookup: every listed nonzero code maps to exactly one transition.
   always_comb begin
      hit     = 1'b0;
      hit_id  = 4'd0;
      hit_src = N0;
      hit_dst = N0;
      case (c_code)
         8'h83: begin hit = 1'b1; hit_id = 4'd1;  hit_src = N0; hit_dst = N2; end
         8'h28: begin hit = 1'b1; hit_id = 4'd2;  hit_src = N1; hit_dst = N3; end
         8'h84: begin hit = 1'b1; hit_id = 4'd3;  hit_src = N2; hit_dst = N2; end
         8'hF5: begin hit = 1'b1; hit_id = 4'd4;  hit_src = N2; hit_dst = N1; end
         8'h8B: begin hit = 1'b1; hit_id = 4'd5;  hit_src = N2; hit_dst = N3; end
         8'h36: begin hit = 1'b1; hit_id = 4'd6;  hit_src = N3; hit_dst = N2; end
         8'h1C: begin hit = 1'b1; hit_id = 4'd7;  hit_src = N3; hit_dst = N4; end
         8'h40: begin hit = 1'b1; hit_id = 4'd8;  hit_src = N3; hit_dst = N3; end
         8'hCF: begin hit = 1'b1; hit_id = 4'd9;  hit_src = N4; hit_dst = N1; end
         8'h46: begin hit = 1'b1; hit_id = 4'd10; hit_src = N4; hit_dst = N5; end
         8'hAE: begin hit = 1'b1; hit_id = 4'd11; hit_src = N4; hit_dst = N3; end
         8'hE7: begin hit = 1'b1; hit_id = 4'd12; hit_src = N4; hit_dst = N0; end
         8'h95: begin hit = 1'b1; hit_id = 4'd13; hit_src = N5; hit_dst = N0; end
         default: ;
      endcase
   end

   assign idle_ok  = (c_code == 8'h00) && (state != N2) && (state != N3);
   assign step_inc = (step_cnt == CNT_MAX) ? step_cnt : step_cnt + CNT_W'(1);
   assign err_inc  = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

   // Next-state and output decision for one automaton step.
   always_comb begin
      state_nx    = state;
      sync_nx     = sync;
      tr_valid_nx = 1'b0;
      tr_id_nx    = tr_id;
      err_nx      = 1'b0;
      step_cnt_nx = step_cnt;
      err_cnt_nx  = err_cnt;
      if (c_valid) begin
         if (sync && idle_ok) begin
            tr_valid_nx = 1'b1;
            tr_id_nx    = 4'd0;
            step_cnt_nx = step_inc;
         end else if (hit && (!sync || hit_src == state)) begin
            // Unsynced: any listed code pins the state, source is not checked.
            state_nx    = hit_dst;
            sync_nx     = 1'b1;
            tr_valid_nx = 1'b1;
            tr_id_nx    = hit_id;
            step_cnt_nx = step_inc;
         end else begin
            sync_nx    = 1'b0;
            err_nx     = 1'b1;
            err_cnt_nx = err_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= N0;
         sync     <= 1'b1;
         tr_valid <= 1'b0;
         tr_id    <= 4'd0;
         err      <= 1'b0;
         step_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         state    <= state_nx;
         sync     <= sync_nx;
         tr_valid <= tr_valid_nx;
         tr_id    <= tr_id_nx;
         err      <= err_nx;
         step_cnt <= step_cnt_nx;
         err_cnt  <= err_cnt_nx;
      end
   end

endmodule

// File: doc/automata_decoder.md
Name: automata_decoder

Overview:
- Decodes the 8-bit micro-operation code stream C produced by the team's six-state Mealy control automaton (states N0..N5) and reconstructs the automaton's state trajectory.
- Identifies each transition, flags codes that are illegal for the tracked state, and re-synchronises after an error.
- Sits on the consumer side of the C bus: it is the observer/decoder end, and the automaton is the encoder end.

Parameters:
- CNT_W, 8, width of the saturating step and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- c_valid  in  1  a new code is present on c_code this cycle (one automaton step).
- c_code  in  8  micro-operation code C.
- state  out  3  tracked automaton state, N0=000 .. N5=101.
- sync  out  1  1 = tracked state is trustworthy.
- tr_valid  out  1  one-cycle pulse: a legal transition was decoded.
- tr_id  out  4  transition index (table below); 0 = idle step.
- err  out  1  one-cycle pulse: illegal code for the tracked state.
- step_cnt  out  CNT_W  legal decoded steps, saturating at all-ones.
- err_cnt  out  CNT_W  illegal codes seen, saturating at all-ones.

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything: state=N0, sync=1, tr_valid=0, tr_id=0, err=0, step_cnt=0, err_cnt=0.
- Timing: all outputs are registered. A step presented with c_valid at edge k is reflected in the outputs after edge k.
- When c_valid=0: state, sync and both counters hold; tr_valid=0, err=0, tr_id holds.
- Transition table, listed as id: from -> to, code:
  1: N0->N2, 83
  2: N1->N3, 28
  3: N2->N2, 84
  4: N2->N1, F5
  5: N2->N3, 8B
  6: N3->N2, 36
  7: N3->N4, 1C
  8: N3->N3, 40
  9: N4->N1, CF
  10: N4->N5, 46
  11: N4->N3, AE
  12: N4->N0, E7
  13: N5->N0, 95
- Idle code 00 is legal only in N0, N1, N4 and N5. On idle: state holds, tr_valid=1, tr_id=0, step_cnt+1.
- Synced (sync=1), valid step with a code that matches the tracked state's row (or a legal idle):
  - state <= destination state.
  - tr_valid=1, tr_id=id, step_cnt+1.
- Synced, valid step with any other code, including 00 in N2/N3, a legal code from the wrong row, or an unlisted value:
  - err=1, err_cnt+1, sync <= 0, state holds.
  - tr_valid=0.
- Unsynced (sync=0), valid step:
  - Every listed nonzero code has a unique destination. On any listed nonzero code: state <= its destination, sync <= 1, tr_valid=1, tr_id=id, step_cnt+1. The source state is not checked.
  - On 00 or an unlisted code: remain unsynced, state holds, err=1, err_cnt+1.
- Counters saturate: at all-ones they stay at all-ones and never wrap.
- Reset asserted together with c_valid: reset wins and the step is dropped.
- X-free: an unlisted code never propagates X into state.

Test Plan:
- Reset, then valid codes 83, 84, F5, 28, 1C, 46, 95 -> state sequence N2, N2, N1, N3, N4, N5, N0; tr_id 1, 3, 4, 2, 7, 10, 13; step_cnt=7; err never asserted.
- From N0, valid 00 three times -> state stays N0; tr_valid pulses with tr_id=0; step_cnt=3.
- Walk to N2 (83), then valid 00 -> err=1 for one cycle, err_cnt=1, sync=0, state stays N2. Then valid 40 -> state=N3, sync=1, tr_id=8.
- Synced in N4, valid 83 (legal code, wrong row) -> err=1, sync=0. Then valid 5A (unlisted) -> err again, err_cnt=2, still unsynced. Then valid E7 -> state=N0, sync=1.
- CNT_W=2: six legal idle steps in N0 -> step_cnt sequence 1, 2, 3, 3, 3, 3 (saturates, no wrap).
- Mid-stream, assert rst in the same cycle as valid AE -> all outputs reach their reset values and the step is ignored. The next valid 83 decodes as tr_id 1.
